// File: rtl/decode_stage_pkg.sv
// Shared decode constants: ALU op codes, RV32I opcodes, immediate/result selectors
// and the control bundle carried from decoder to execute.
package decode_stage_pkg;

  // Contiguous groups let the decoder form ops as base + funct3
  localparam logic [5:0] ALU_NONE   = 6'd0;
  localparam logic [5:0] ALU_ADD    = 6'd1;
  localparam logic [5:0] ALU_SLL    = 6'd2;
  localparam logic [5:0] ALU_SLT    = 6'd3;
  localparam logic [5:0] ALU_SLTU   = 6'd4;
  localparam logic [5:0] ALU_XOR    = 6'd5;
  localparam logic [5:0] ALU_SRL    = 6'd6;
  localparam logic [5:0] ALU_OR     = 6'd7;
  localparam logic [5:0] ALU_AND    = 6'd8;
  localparam logic [5:0] ALU_SUB    = 6'd9;
  localparam logic [5:0] ALU_SRA    = 6'd10;
  localparam logic [5:0] ALU_ADDI   = 6'd11;
  localparam logic [5:0] ALU_SLLI   = 6'd12;
  localparam logic [5:0] ALU_SLTI   = 6'd13;
  localparam logic [5:0] ALU_SLTIU  = 6'd14;
  localparam logic [5:0] ALU_XORI   = 6'd15;
  localparam logic [5:0] ALU_SRLI   = 6'd16;
  localparam logic [5:0] ALU_ORI    = 6'd17;
  localparam logic [5:0] ALU_ANDI   = 6'd18;
  localparam logic [5:0] ALU_SRAI   = 6'd19;
  localparam logic [5:0] ALU_BEQ    = 6'd20;
  localparam logic [5:0] ALU_BNE    = 6'd21;
  localparam logic [5:0] ALU_BLT    = 6'd24;
  localparam logic [5:0] ALU_BGE    = 6'd25;
  localparam logic [5:0] ALU_BLTU   = 6'd26;
  localparam logic [5:0] ALU_BGEU   = 6'd27;
  localparam logic [5:0] ALU_LUI    = 6'd28;
  localparam logic [5:0] ALU_AUIPC  = 6'd29;
  localparam logic [5:0] ALU_JAL    = 6'd30;
  localparam logic [5:0] ALU_JALR   = 6'd31;
  localparam logic [5:0] ALU_MUL    = 6'd32;
  localparam logic [5:0] ALU_MULH   = 6'd33;
  localparam logic [5:0] ALU_MULHSU = 6'd34;
  localparam logic [5:0] ALU_MULHU  = 6'd35;
  localparam logic [5:0] ALU_DIV    = 6'd36;
  localparam logic [5:0] ALU_DIVU   = 6'd37;
  localparam logic [5:0] ALU_REM    = 6'd38;
  localparam logic [5:0] ALU_REMU   = 6'd39;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_U = 3'd1;
  localparam logic [2:0] IMM_J = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_S = 3'd4;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [5:0] alu_op;
    logic       alu_input_config;
    logic [2:0] imm_sel;
    logic       reg_write_enable;
    logic       result_src;
    logic       is_branch;
    logic       is_jump;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       illegal;
    logic       ecall;
    logic       ebreak;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I(+M) instruction-to-control table with immediate generation.
module instr_decoder
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic        wr;
  logic        is_shift;
  logic [31:0] imm32;
  ctrl_t       dec;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec          = '0;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    legal        = 1'b1;
    wr           = 1'b0;
    is_shift     = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.alu_input_config = 1'b1;
        wr                   = 1'b1;
        dec.alu_op           = ALU_ADDI + 6'(f3);
        if (f3 == 3'b001) begin
          is_shift = 1'b1;
          legal    = (f7 == 7'b0000000);
        end else if (f3 == 3'b101) begin
          is_shift = 1'b1;
          legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          if (f7[5]) dec.alu_op = ALU_SRAI;
        end
      end
      OPC_OP: begin
        wr = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_op = ALU_ADD + 6'(f3);
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.alu_op = ALU_SRA;
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          dec.alu_op = ALU_MUL + 6'(f3);
        end else begin
          legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        legal                = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        dec.alu_op           = ALU_ADD;
        dec.alu_input_config = 1'b1;
        dec.result_src       = RES_MEM;
        dec.mem_read         = 1'b1;
        dec.mem_size         = f3;
        wr                   = 1'b1;
      end
      OPC_STORE: begin
        legal                = (f3 < 3'b011);
        dec.alu_op           = ALU_ADD;
        dec.alu_input_config = 1'b1;
        dec.imm_sel          = IMM_S;
        dec.mem_write        = 1'b1;
        dec.mem_size         = f3;
      end
      OPC_BRANCH: begin
        legal         = (f3 != 3'b010) && (f3 != 3'b011);
        dec.alu_op    = ALU_BEQ + 6'(f3);
        dec.imm_sel   = IMM_B;
        dec.is_branch = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_op  = ALU_JAL;
        dec.imm_sel = IMM_J;
        dec.is_jump = 1'b1;
        wr          = 1'b1;
      end
      OPC_JALR: begin
        legal                = (f3 == 3'b000);
        dec.alu_op           = ALU_JALR;
        dec.alu_input_config = 1'b1;
        dec.is_jump          = 1'b1;
        wr                   = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.alu_op  = (opcode == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
        dec.imm_sel = IMM_U;
        wr          = 1'b1;
      end
      // FENCE has no effect on an in-order core; it passes as a no-op
      OPC_MISC_MEM: legal = (f3 == 3'b000);
      OPC_SYSTEM: begin
        dec.ecall  = (instr == INSTR_ECALL);
        dec.ebreak = (instr == INSTR_EBREAK);
        legal      = dec.ecall || dec.ebreak;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      dec.illegal = 1'b1;
    end
    dec.reg_write_enable = wr && legal && (dec.rd != 5'd0);
    ctrl = dec;
  end

  always_comb begin
    case (dec.imm_sel)
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_S:   imm32 = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      default: imm32 = {{21{instr[31]}}, instr[30:20]};
    endcase
    imm = is_shift ? XLEN'(instr[24:20]) : XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main output register plus one skid entry so that
// in_ready never depends combinationally on out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_alu_op,
  output logic            out_alu_input_config,
  output logic [2:0]      out_imm_sel,
  output logic            out_reg_write_enable,
  output logic            out_result_src,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [2:0]      out_mem_size,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  instr_decoder #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_instr_decoder (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  logic            main_valid_reg, main_valid_next;
  ctrl_t           main_ctrl_reg, main_ctrl_next;
  logic [XLEN-1:0] main_imm_reg, main_imm_next;
  logic [XLEN-1:0] main_pc_reg, main_pc_next;
  logic            skid_valid_reg, skid_valid_next;
  ctrl_t           skid_ctrl_reg, skid_ctrl_next;
  logic [XLEN-1:0] skid_imm_reg, skid_imm_next;
  logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
  logic            accept;
  logic            drain;

  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_reg && out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_imm_next   = main_imm_reg;
    main_pc_next    = main_pc_reg;
    skid_valid_next = skid_valid_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_imm_next   = skid_imm_reg;
    skid_pc_next    = skid_pc_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || drain) begin
      // Skid is older than anything arriving now (and blocks arrivals anyway)
      if (skid_valid_reg) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = skid_ctrl_reg;
        main_imm_next   = skid_imm_reg;
        main_pc_next    = skid_pc_reg;
        skid_valid_next = 1'b0;
      end else begin
        main_valid_next = accept;
        if (accept) begin
          main_ctrl_next = dec_ctrl;
          main_imm_next  = dec_imm;
          main_pc_next   = in_pc;
        end
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_ctrl_next  = dec_ctrl;
      skid_imm_next   = dec_imm;
      skid_pc_next    = in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= '0;
      main_imm_reg   <= '0;
      main_pc_reg    <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_imm_reg   <= '0;
      skid_pc_reg    <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_imm_reg   <= main_imm_next;
      main_pc_reg    <= main_pc_next;
      skid_valid_reg <= skid_valid_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_imm_reg   <= skid_imm_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

  assign out_valid            = main_valid_reg;
  assign out_pc               = main_pc_reg;
  assign out_imm              = main_imm_reg;
  assign out_rs1              = main_ctrl_reg.rs1;
  assign out_rs2              = main_ctrl_reg.rs2;
  assign out_rd               = main_ctrl_reg.rd;
  assign out_alu_op           = main_ctrl_reg.alu_op;
  assign out_alu_input_config = main_ctrl_reg.alu_input_config;
  assign out_imm_sel          = main_ctrl_reg.imm_sel;
  assign out_reg_write_enable = main_ctrl_reg.reg_write_enable;
  assign out_result_src       = main_ctrl_reg.result_src;
  assign out_is_branch        = main_ctrl_reg.is_branch;
  assign out_is_jump          = main_ctrl_reg.is_jump;
  assign out_mem_read         = main_ctrl_reg.mem_read;
  assign out_mem_write        = main_ctrl_reg.mem_write;
  assign out_mem_size         = main_ctrl_reg.mem_size;
  assign out_illegal          = main_ctrl_reg.illegal;
  assign out_ecall            = main_ctrl_reg.ecall;
  assign out_ebreak           = main_ctrl_reg.ebreak;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-written expected decodes go into a
// scoreboard at acceptance and are compared when execute takes each entry.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [5:0]  out_alu_op;
  logic [2:0]  out_imm_sel, out_mem_size;
  logic        out_alu_input_config, out_reg_write_enable, out_result_src;
  logic        out_is_branch, out_is_jump, out_mem_read, out_mem_write;
  logic        out_illegal, out_ecall, out_ebreak;

  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_pc, m_out_imm;
  logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
  logic [5:0]  m_out_alu_op;
  logic [2:0]  m_out_imm_sel, m_out_mem_size;
  logic        m_out_alu_input_config, m_out_reg_write_enable, m_out_result_src;
  logic        m_out_is_branch, m_out_is_jump, m_out_mem_read, m_out_mem_write;
  logic        m_out_illegal, m_out_ecall, m_out_ebreak;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_input_config(out_alu_input_config),
    .out_imm_sel(out_imm_sel), .out_reg_write_enable(out_reg_write_enable),
    .out_result_src(out_result_src), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
    .out_illegal(out_illegal), .out_ecall(out_ecall), .out_ebreak(out_ebreak)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd),
    .out_imm(m_out_imm), .out_alu_op(m_out_alu_op), .out_alu_input_config(m_out_alu_input_config),
    .out_imm_sel(m_out_imm_sel), .out_reg_write_enable(m_out_reg_write_enable),
    .out_result_src(m_out_result_src), .out_is_branch(m_out_is_branch), .out_is_jump(m_out_is_jump),
    .out_mem_read(m_out_mem_read), .out_mem_write(m_out_mem_write), .out_mem_size(m_out_mem_size),
    .out_illegal(m_out_illegal), .out_ecall(m_out_ecall), .out_ebreak(m_out_ebreak)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic [5:0] alu_op;
    logic       aic;
    logic [2:0] imm_sel;
    logic       rwe, rsrc, br, jmp, mr, mw;
    logic [2:0] msize;
    logic       ill, ec, eb;
  } fields_t;

  typedef struct {
    logic [31:0] pc;
    logic        imm_chk;
    logic [31:0] imm;
    fields_t     f;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  exp_t e;
  bit   accepted;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] pc, logic [31:0] instr);
    exp_t r;
    r.pc      = pc;
    r.imm_chk = 1'b0;
    r.imm     = '0;
    r.f       = '0;
    r.f.rs1   = instr[19:15];
    r.f.rs2   = instr[24:20];
    r.f.rd    = instr[11:7];
    return r;
  endfunction

  function automatic logic [31:0] addi_instr(logic [4:0] rd, logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic exp_t addi_exp(logic [31:0] pc, logic [4:0] rd, logic [11:0] imm);
    exp_t r;
    r           = mk(pc, addi_instr(rd, imm));
    r.imm_chk   = 1'b1;
    r.imm       = {20'd0, imm};
    r.f.alu_op  = ALU_ADDI;
    r.f.aic     = 1'b1;
    r.f.rwe     = 1'b1;
    return r;
  endfunction

  // One clock: consume/produce at negedge, then return just after posedge
  task automatic tick();
    fields_t obs;
    exp_t    x;
    @(negedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_output: observed pc %h expected no entry", out_pc);
        end
        if (q.size() > 0) begin
          x   = q.pop_front();
          obs = {out_rs1, out_rs2, out_rd, out_alu_op, out_alu_input_config, out_imm_sel,
                 out_reg_write_enable, out_result_src, out_is_branch, out_is_jump,
                 out_mem_read, out_mem_write, out_mem_size, out_illegal, out_ecall, out_ebreak};
          $display("txn pc=%h rd=%0d alu_op=%0d imm=%h illegal=%b", out_pc, out_rd,
                   out_alu_op, out_imm, out_illegal);
          check("pc", out_pc, x.pc);
          check("fields", obs, x.f);
          if (x.imm_chk) check("imm", out_imm, x.imm);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(pend);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(exp_t x, logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = x.pc;
    pend     = x;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) tick();
    check("accept_timeout", accepted, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    check("drain_left", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_rd", out_rd, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADDI x1,x0,5 with 1-cycle latency
    offer(addi_exp(32'h0, 5'd1, 12'd5), 32'h0050_0093);
    check("addi_latency_valid", out_valid, 1'b1);
    drain_all();

    e = mk(32'h100, 32'hFE00_0EE3);
    e.imm_chk = 1'b1; e.imm = 32'hFFFF_FFFC;
    e.f.alu_op = ALU_BEQ; e.f.imm_sel = IMM_B; e.f.br = 1'b1;
    offer(e, 32'hFE00_0EE3);
    drain_all();

    // MUL: illegal without M, legal with M
    e = mk(32'h104, 32'h0220_81B3);
    e.f.ill = 1'b1;
    offer(e, 32'h0220_81B3);
    check("m_valid", m_out_valid, 1'b1);
    check("m_alu_op", m_out_alu_op, ALU_MUL);
    check("m_rd", m_out_rd, 5'd3);
    check("m_rwe", m_out_reg_write_enable, 1'b1);
    check("m_illegal", m_out_illegal, 1'b0);
    drain_all();

    e = mk(32'h108, 32'hFFFF_FFFF); e.f.ill = 1'b1;
    offer(e, 32'hFFFF_FFFF);
    e = mk(32'h10C, 32'h0230_D093); e.f.ill = 1'b1;
    offer(e, 32'h0230_D093);
    e = mk(32'h110, 32'h41F0_D113);
    e.imm_chk = 1'b1; e.imm = 32'h1F;
    e.f.alu_op = ALU_SRAI; e.f.aic = 1'b1; e.f.rwe = 1'b1;
    offer(e, 32'h41F0_D113);
    e = mk(32'h114, 32'hFF81_2283);
    e.imm_chk = 1'b1; e.imm = 32'hFFFF_FFF8;
    e.f.alu_op = ALU_ADD; e.f.aic = 1'b1; e.f.rsrc = RES_MEM; e.f.mr = 1'b1;
    e.f.msize = 3'b010; e.f.rwe = 1'b1;
    offer(e, 32'hFF81_2283);
    e = mk(32'h118, 32'h0051_2623);
    e.imm_chk = 1'b1; e.imm = 32'h0000_000C;
    e.f.alu_op = ALU_ADD; e.f.aic = 1'b1; e.f.imm_sel = IMM_S; e.f.mw = 1'b1;
    e.f.msize = 3'b010;
    offer(e, 32'h0051_2623);
    e = mk(32'h11C, 32'h8000_03B7);
    e.imm_chk = 1'b1; e.imm = 32'h8000_0000;
    e.f.alu_op = ALU_LUI; e.f.imm_sel = IMM_U; e.f.rwe = 1'b1;
    offer(e, 32'h8000_03B7);
    e = mk(32'h120, 32'h0080_00EF);
    e.imm_chk = 1'b1; e.imm = 32'h0000_0008;
    e.f.alu_op = ALU_JAL; e.f.imm_sel = IMM_J; e.f.jmp = 1'b1; e.f.rwe = 1'b1;
    offer(e, 32'h0080_00EF);
    e = mk(32'h124, 32'h0000_0073); e.f.ec = 1'b1;
    offer(e, 32'h0000_0073);
    e = mk(32'h128, 32'h0010_0073); e.f.eb = 1'b1;
    offer(e, 32'h0010_0073);
    e = mk(32'h12C, 32'h0000_90E7); e.f.ill = 1'b1;
    offer(e, 32'h0000_90E7);
    drain_all();

    // Backpressure: two fit, third stalls, then all three drain in order
    out_ready = 1'b0;
    offer(addi_exp(32'h200, 5'd1, 12'd5), addi_instr(5'd1, 12'd5));
    offer(addi_exp(32'h204, 5'd2, 12'd6), addi_instr(5'd2, 12'd6));
    check("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = addi_instr(5'd3, 12'd7); in_pc = 32'h208;
    pend = addi_exp(32'h208, 5'd3, 12'd7); accepted = 1'b0;
    tick();
    check("bp_third_stalled", accepted, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && !accepted; i++) tick();
    check("bp_third_accepted", accepted, 1'b1);
    in_valid = 1'b0;
    drain_all();

    // Flush with both entries full and a concurrent offer
    out_ready = 1'b0;
    offer(addi_exp(32'h300, 5'd4, 12'd1), addi_instr(5'd4, 12'd1));
    offer(addi_exp(32'h304, 5'd5, 12'd2), addi_instr(5'd5, 12'd2));
    flush = 1'b1; in_valid = 1'b1; in_instr = addi_instr(5'd6, 12'd9); in_pc = 32'h308;
    pend = addi_exp(32'h308, 5'd6, 12'd9);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_no_output", out_valid, 1'b0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    offer(addi_exp(32'h400, 5'd7, 12'd3), addi_instr(5'd7, 12'd3));
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_rd", out_rd, 5'd0);
    check("arst_out_imm", out_imm, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    offer(addi_exp(32'h500, 5'd8, 12'd4), addi_instr(5'd8, 12'd4));
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I decode stage that sits between fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake and outputs fully decoded control fields plus a sign-extended immediate.
- Flags illegal encodings and optionally decodes the M extension.
- A 2-entry skid buffer keeps full throughput under execute backpressure, and a synchronous flush discards in-flight entries on a redirect.

Parameters:
- XLEN, 32, width of PC and immediate datapath (≥32); decode is always RV32I.
- ENABLE_M, 0, 1 = decode MUL/DIV/REM (funct7 0000001) as legal; 0 = treat as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  passthrough PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  6  ALU operation code (shared constants).
- out_alu_input_config  out  1  0 = rs1,rs2; 1 = rs1,imm.
- out_imm_sel  out  3  0 I, 1 U, 2 J, 3 B, 4 S.
- out_reg_write_enable  out  1  write rd.
- out_result_src  out  1  0 = ALU, 1 = memory.
- out_is_branch, out_is_jump  out  1 each  conditional branch; JAL/JALR.
- out_mem_read, out_mem_write  out  1 each  load; store.
- out_mem_size  out  3  funct3 of load/store.
- out_illegal, out_ecall, out_ebreak  out  1 each  exception flags.

Behaviour:
- Handshake and latency:
  - Transfer occurs when valid&&ready on the rising edge.
  - An instruction accepted at edge N is visible on the outputs after edge N (1-cycle latency) when the main register is empty or draining.
- Storage: main register (drives outputs) plus skid register.
  - in_ready = !skid_valid; it is a register output with no combinational path from out_ready.
  - Accept while main is full and not draining: the entry goes to skid.
  - Main drains: skid moves to main; if skid is empty, a concurrent accept loads main.
  - Order is strictly FIFO. Sustained throughput is 1/cycle.
- Flush:
  - Clears main_valid and skid_valid at the next edge.
  - A concurrent in_valid is dropped; flush has priority over accept and drain.
  - in_ready is 1 the cycle after flush.
- Reset:
  - Asynchronous; clears both valid bits and every output field to 0, so in_ready=1.
  - Reset mid-transfer loses all entries; no partial state survives.
- Decode rules:
  - Register indices are copied from the fixed fields regardless of format.
  - out_reg_write_enable=0 when rd==0, for branches/stores/ECALL/EBREAK, or when illegal.
  - OP-IMM, LOAD, JALR, STORE: alu_input_config=1. Loads: result_src=1, mem_read=1. Stores: mem_write=1, imm_sel=4.
  - Branches: is_branch=1, imm_sel=3.
  - JAL: is_jump=1, imm_sel=2. JALR: is_jump=1, imm_sel=0.
  - LUI/AUIPC: imm_sel=1; imm = instr[31:12]<<12, sign-extended.
  - SLLI/SRLI/SRAI: instr[25]=1 is illegal; imm = shamt zero-extended.
- Illegal encodings (out_illegal=1; all write/mem/branch/jump flags 0; alu_op=0):
  - unknown opcode;
  - reserved funct3 (LOAD 011/110/111, STORE ≥011, BRANCH 010/011, JALR ≠000);
  - funct7 other than 0000000/0100000, or 0000001 with ENABLE_M=1, for OP;
  - SYSTEM word other than exact ECALL 0x00000073 / EBREAK 0x00100073.
- out_imm is sign-extended from instr[31] to XLEN for all formats except shifts.

Decomposition:
- Shared constants file (existing global include):
  - all 6-bit ALU op codes (RV32I + MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU);
  - opcode values;
  - imm_sel codes;
  - result_src codes.
- Sub-module instr_decoder: purely combinational instruction-to-control-bundle table with ENABLE_M and XLEN parameters.
- decode_stage instantiates it once on in_instr and holds only the skid/handshake registers.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1:
  - next cycle out_valid=1, rd=1, imm=5, alu_op=`ADDI, alu_input_config=1, imm_sel=0, reg_write_enable=1, result_src=0.
- BEQ x0,x0,-4 (0xFE000EE3), in_pc=0x100:
  - out_imm=0xFFFFFFFC, is_branch=1, imm_sel=3, reg_write_enable=0, out_pc=0x100.
- Backpressure: hold out_ready=0, feed 3 instructions back-to-back:
  - first two accepted, in_ready=0 on the third;
  - raise out_ready: three outputs emerge in order, one per cycle, none lost or duplicated.
- MUL x3,x1,x2 (0x022081B3):
  - ENABLE_M=0 gives out_illegal=1, reg_write_enable=0;
  - ENABLE_M=1 gives alu_op=`MUL, rd=3, reg_write_enable=1.
- 0xFFFFFFFF and SRLI with instr[25]=1:
  - out_illegal=1, all side-effect flags 0.
- Both entries full, assert flush with in_valid=1:
  - next cycle out_valid=0, in_ready=1, dropped instruction never appears.
- Assert rst mid-stream:
  - outputs clear immediately, without waiting for a clock edge.
